// File: rtl/rom_bank.sv
// Lockable program-memory bank on a RIB slave port.
// A registered req/ack handshake serves reads with RD_LAT latency. Writes are byte-enabled and ack in one cycle.
module rom_bank #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   data_i,
    input  logic                lock_i,
    output logic [DATA_W-1:0]   data_o,
    output logic                ack_o,
    output logic                err_o,
    output logic                locked_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned WA_W  = ADDR_W - 2;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t             state;
    logic [1:0]         cnt;
    logic [IDX_W-1:0]   idx_q;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic [IDX_W-1:0]   idx_c;
    logic [WA_W-1:0]    word_c;
    logic               misal_c;
    logic               oor_c;
    logic               wlock_c;
    logic               err_c;
    logic               wr_c;

    // Request decode; the error checks apply only at accept
    always_comb begin
        idx_c   = addr_i[IDX_W+1:2];
        word_c  = addr_i[ADDR_W-1:2];
        misal_c = |addr_i[1:0];
        oor_c   = |(word_c >> IDX_W);
        wlock_c = we_i & (locked_o | lock_i);
        err_c   = misal_c | oor_c | wlock_c;
        wr_c    = (state == IDLE) & req_i & we_i & ~err_c;
    end

    // Storage: writes commit on the accept edge. rst does not clear memory.
    always_ff @(posedge clk) begin
        if (wr_c) begin
            for (int k = 0; k < NB; k++) begin
                if (be_i[k]) mem[idx_c][8*k +: 8] <= data_i[8*k +: 8];
            end
        end
    end

    // Handshake FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            idx_q    <= '0;
            data_o   <= '0;
            ack_o    <= 1'b0;
            err_o    <= 1'b0;
            locked_o <= 1'b0;
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            if (lock_i) locked_o <= 1'b1;
            case (state)
                IDLE: begin
                    if (req_i) begin
                        idx_q <= idx_c;
                        if (err_c || we_i) begin
                            state <= ACK;
                            ack_o <= 1'b1;
                            err_o <= err_c;
                        end else if (RD_LAT == 1) begin
                            state  <= ACK;
                            ack_o  <= 1'b1;
                            data_o <= mem[idx_c];
                        end else begin
                            state <= WAIT;
                            cnt   <= 2'(RD_LAT - 2);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 2'd0) begin
                        state  <= ACK;
                        ack_o  <= 1'b1;
                        data_o <= mem[idx_q];
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_bank.sv
// Directed bench for rom_bank (DEPTH=1024, RD_LAT=2).
// It checks handshake latency, byte enables, error paths, lock behaviour and reset during a pending read.
module tb_rom_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic        lock_i;
    logic [31:0] data_o;
    logic        ack_o;
    logic        err_o;
    logic        locked_o;

    int n_tests = 0;
    int n_fail  = 0;

    rom_bank #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32), .RD_LAT(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_i),
        .we_i     (we_i),
        .be_i     (be_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .lock_i   (lock_i),
        .data_o   (data_o),
        .ack_o    (ack_o),
        .err_o    (err_o),
        .locked_o (locked_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One single-cycle request. lat is the number of cycles from accept to ack (1 = right after the accept edge). A timeout leaves lat at 0.
    task automatic xact(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, input logic lk,
                        output int lat, output logic err, output logic [31:0] rd);
        req_i = 1'b1; we_i = we; be_i = be; addr_i = addr; data_i = wd; lock_i = lk;
        tick();
        req_i = 1'b0; lock_i = 1'b0;
        lat = 0; err = 1'bx; rd = 'x;
        for (int n = 1; n <= 8; n++) begin
            if (ack_o) begin
                lat = n; err = err_o; rd = data_o;
                break;
            end
            tick();
        end
        if (lat != 0) tick();
    endtask

    int          lat;
    logic        err;
    logic [31:0] rd;
    int          t_ack [3];
    int          n_ack;

    initial begin
        rst = 1'b1; req_i = 1'b0; we_i = 1'b0; be_i = 4'h0;
        addr_i = '0; data_i = '0; lock_i = 1'b0;
        tick(); tick();
        chk("rst_data",   data_o,   32'h0);
        chk("rst_ack",    32'(ack_o),    32'd0);
        chk("rst_err",    32'(err_o),    32'd0);
        chk("rst_locked", 32'(locked_o), 32'd0);
        rst = 1'b0;
        tick();

        // Write then read
        xact(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, lat, err, rd);
        chk("wr_lat", 32'(lat), 32'd1);
        chk("wr_err", 32'(err), 32'd0);
        xact(1'b0, 4'h0, 32'h10, 32'h0, 1'b0, lat, err, rd);
        chk("rd_lat",  32'(lat), 32'd2);
        chk("rd_err",  32'(err), 32'd0);
        chk("rd_data", rd, 32'hDEADBEEF);

        // Byte enables
        xact(1'b1, 4'hF, 32'h20, 32'h11223344, 1'b0, lat, err, rd);
        xact(1'b1, 4'h5, 32'h20, 32'hAABBCCDD, 1'b0, lat, err, rd);
        chk("be_wr_err", 32'(err), 32'd0);
        xact(1'b0, 4'h0, 32'h20, 32'h0, 1'b0, lat, err, rd);
        chk("be_data", rd, 32'h11BB33DD);
        xact(1'b1, 4'h0, 32'h20, 32'h0, 1'b0, lat, err, rd);
        chk("be0_lat", 32'(lat), 32'd1);
        chk("be0_err", 32'(err), 32'd0);
        xact(1'b0, 4'h0, 32'h20, 32'h0, 1'b0, lat, err, rd);
        chk("be0_data", rd, 32'h11BB33DD);

        // Error paths
        xact(1'b0, 4'h0, 32'h1002, 32'h0, 1'b0, lat, err, rd);
        chk("misal_lat",  32'(lat), 32'd1);
        chk("misal_err",  32'(err), 32'd1);
        chk("misal_hold", rd, 32'h11BB33DD);
        xact(1'b0, 4'h0, 32'h1000, 32'h0, 1'b0, lat, err, rd);
        chk("oor_rd_err",  32'(err), 32'd1);
        chk("oor_rd_hold", rd, 32'h11BB33DD);
        xact(1'b1, 4'hF, 32'h0, 32'h01234567, 1'b0, lat, err, rd);
        xact(1'b1, 4'hF, 32'h1000, 32'h55555555, 1'b0, lat, err, rd);
        chk("oor_wr_lat", 32'(lat), 32'd1);
        chk("oor_wr_err", 32'(err), 32'd1);
        xact(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, lat, err, rd);
        chk("oor_wr_nochg", rd, 32'h01234567);
        xact(1'b1, 4'hF, 32'h12, 32'h0, 1'b0, lat, err, rd);
        chk("misal_wr_err", 32'(err), 32'd1);
        xact(1'b0, 4'h0, 32'h10, 32'h0, 1'b0, lat, err, rd);
        chk("misal_wr_nochg", rd, 32'hDEADBEEF);

        // req_i held high through three reads; drop it during the third ACK
        n_ack = 0;
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h20;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (ack_o) begin
                if (n_ack < 3) t_ack[n_ack] = c;
                n_ack++;
                if (n_ack == 3) req_i = 1'b0;
            end
        end
        req_i = 1'b0;
        chk("bb_count", 32'(n_ack), 32'd3);
        chk("bb_first", 32'(t_ack[0]), 32'd2);
        chk("bb_gap01", 32'(t_ack[1] - t_ack[0]), 32'd3);
        chk("bb_gap12", 32'(t_ack[2] - t_ack[1]), 32'd3);
        chk("bb_data",  data_o, 32'h11BB33DD);

        // Lock pulse, then a write must be rejected
        lock_i = 1'b1; tick(); lock_i = 1'b0; tick();
        chk("lock_sticky", 32'(locked_o), 32'd1);
        xact(1'b1, 4'hF, 32'h10, 32'h0, 1'b0, lat, err, rd);
        chk("lock_wr_lat", 32'(lat), 32'd1);
        chk("lock_wr_err", 32'(err), 32'd1);
        xact(1'b0, 4'h0, 32'h10, 32'h0, 1'b0, lat, err, rd);
        chk("lock_rd_data", rd, 32'hDEADBEEF);

        // Reset during WAIT: pending read dropped, lock cleared, memory kept
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h20;
        tick();
        req_i = 1'b0; rst = 1'b1;
        tick();
        chk("rstw_ack",    32'(ack_o),    32'd0);
        chk("rstw_data",   data_o,        32'h0);
        chk("rstw_err",    32'(err_o),    32'd0);
        chk("rstw_locked", 32'(locked_o), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rstw_noack", 32'(ack_o), 32'd0);
        end
        xact(1'b0, 4'h0, 32'h10, 32'h0, 1'b0, lat, err, rd);
        chk("rstw_mem", rd, 32'hDEADBEEF);

        // lock_i on the same edge as a write request
        xact(1'b1, 4'hF, 32'h10, 32'h0, 1'b1, lat, err, rd);
        chk("same_lock_err", 32'(err), 32'd1);
        chk("same_locked",   32'(locked_o), 32'd1);
        xact(1'b0, 4'h0, 32'h10, 32'h0, 1'b0, lat, err, rd);
        chk("same_mem", rd, 32'hDEADBEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
